// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply control slice.
package matmul_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DIM        = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    FLUSH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Index/address width for n distinct values, never narrower than 1 bit.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/mac_sequencer_if.sv
// Control, operand-fetch, data_path and result-memory signals of mac_sequencer.
interface mac_sequencer_if
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = addr_width(DEF_DIM * DEF_DIM)
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr_A;
  logic [ADDR_WIDTH-1:0] addr_B;
  logic                  en_Mux;
  logic                  en_PPReg;
  logic                  en_FDReg;
  logic [DATA_WIDTH-1:0] outData;
  logic                  resultIsInvalid;
  logic                  res_wr_en;
  logic [ADDR_WIDTH-1:0] res_addr;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  overflow;

  modport master (
    input  start, outData, resultIsInvalid,
    output busy, done, rd_en, addr_A, addr_B, en_Mux, en_PPReg, en_FDReg,
           res_wr_en, res_addr, res_data, overflow
  );

  modport slave (
    output start, outData, resultIsInvalid,
    input  busy, done, rd_en, addr_A, addr_B, en_Mux, en_PPReg, en_FDReg,
           res_wr_en, res_addr, res_data, overflow
  );
endinterface

// File: rtl/mac_index_gen.sv
// i/j/k loop counters for C = A x B with row-major operand/result addresses.
module mac_index_gen
  import matmul_pkg::*;
#(
  parameter int DIM        = DEF_DIM,
  parameter int ADDR_WIDTH = addr_width(DIM * DIM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  k_step,
  input  logic                  ij_step,
  output logic                  k_first,
  output logic                  k_last,
  output logic                  j_last,
  output logic                  i_last,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic [ADDR_WIDTH-1:0] addr_B,
  output logic [ADDR_WIDTH-1:0] res_addr
);
  localparam int IDX_W = addr_width(DIM);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DIM);

  logic [IDX_W-1:0] i, j, k;

  assign k_first = (k == '0);
  assign k_last  = (k == LAST);
  assign j_last  = (j == LAST);
  assign i_last  = (i == LAST);

  assign addr_A   = ADDR_WIDTH'(i) * STRIDE + ADDR_WIDTH'(k);
  assign addr_B   = ADDR_WIDTH'(k) * STRIDE + ADDR_WIDTH'(j);
  assign res_addr = ADDR_WIDTH'(i) * STRIDE + ADDR_WIDTH'(j);

  // k steps through the dot product; j, then i, step once per written result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else if (clear) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (k_step) k <= k_last ? '0 : k + 1'b1;
      if (ij_step) begin
        j <= j_last ? '0 : j + 1'b1;
        if (j_last) i <= i_last ? '0 : i + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mac_sequencer.sv
// Sequences operand fetch, data_path enables and result writes for C = A x B.
module mac_sequencer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM        = DEF_DIM,
  parameter int ADDR_WIDTH = addr_width(DIM * DIM)
) (
  input  logic           clk,
  input  logic           reset,
  mac_sequencer_if.master bus
);
  state_t state, next_state;

  logic                  accept;
  logic                  rd_en, res_wr_en, busy, done;
  logic                  k_first, k_last, j_last, i_last;
  logic [ADDR_WIDTH-1:0] addr_A, addr_B, res_addr;
  logic                  pp_q, mux_q, fd_q;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] res_data;

  assign accept = (state == IDLE) && bus.start;

  mac_index_gen #(.DIM(DIM), .ADDR_WIDTH(ADDR_WIDTH)) u_index (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .k_step   (state == RUN),
    .ij_step  (state == WRITE),
    .k_first  (k_first),
    .k_last   (k_last),
    .j_last   (j_last),
    .i_last   (i_last),
    .addr_A   (addr_A),
    .addr_B   (addr_B),
    .res_addr (res_addr)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and per-state strobes.
  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    res_wr_en  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (bus.start) next_state = RUN;
      RUN: begin
        busy  = 1'b1;
        rd_en = 1'b1;
        if (k_last) next_state = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        next_state = WRITE;
      end
      WRITE: begin
        busy       = 1'b1;
        res_wr_en  = 1'b1;
        next_state = (i_last && j_last) ? DONE : RUN;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Enable stage trails the fetch by one cycle to line up with memory read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pp_q  <= 1'b0;
      mux_q <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      pp_q  <= rd_en;
      mux_q <= rd_en & ~k_first;
      fd_q  <= rd_en & k_last;
    end
  end

  // Sticky overflow across one run, cleared when a new run is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   overflow_q <= 1'b0;
    else if (accept)                             overflow_q <= 1'b0;
    else if (state == WRITE && bus.resultIsInvalid) overflow_q <= 1'b1;
  end

  // outData is the data_path final register, so res_data only needs gating.
  assign res_data = res_wr_en ? bus.outData : '0;

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.rd_en     = rd_en;
  assign bus.addr_A    = rd_en ? addr_A : '0;
  assign bus.addr_B    = rd_en ? addr_B : '0;
  assign bus.en_PPReg  = pp_q;
  assign bus.en_Mux    = mux_q;
  assign bus.en_FDReg  = fd_q;
  assign bus.res_wr_en = res_wr_en;
  assign bus.res_addr  = res_wr_en ? res_addr : '0;
  assign bus.res_data  = res_data;
  assign bus.overflow  = overflow_q;
endmodule
